cam_window_capture: RTL and testbench

- Parametrised successor to the single-camera capture logic. Decodes OV-style camera timing (pclk/vsync/href, PIX_PHASES bus cycles per pixel) into pixel x/y coordinates.
- Writes pixels falling inside NUM_WIN independently programmable rectangular windows into per-window RAM ports, with optional power-of-two decimation.
- Window configuration is shadowed at vsync; per-window overflow and frame-done status go to the distance-calculation logic.
- Sits between the camera pins and the display/calculation dual-port RAMs.

---
 rtl/cam_pkg.sv | 29 ++
 rtl/cam_window_capture_if.sv | 27 ++
 rtl/cam_win_writer.sv | 92 +++++++++
 rtl/cam_window_capture.sv | 127 ++++++++++++
 tb/tb_cam_window_capture.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared defaults and config-bus helpers for the windowed camera capture.
package cam_pkg;

  localparam int DATA_W_DEF     = 3;
  localparam int X_W_DEF        = 10;
  localparam int Y_W_DEF        = 9;
  localparam int ADDR_W_DEF     = 16;
  localparam int NUM_WIN_DEF    = 2;
  localparam int PIX_PHASES_DEF = 2;
  localparam int DEC_W_DEF      = 2;

  localparam int BUS_MAX   = 512;
  localparam int FIELD_MAX = 32;

  typedef logic [BUS_MAX-1:0]   bus_t;
  typedef logic [FIELD_MAX-1:0] field_t;

  // Field k of width w from a flattened per-window config bus.
  function automatic field_t slice(
    input bus_t bus,
    input int   k,
    input int   w
  );
    bus_t t;
    t = bus >> (k * w);
    return t[FIELD_MAX-1:0] & ~({FIELD_MAX{1'b1}} << w);
  endfunction

endpackage

// File: rtl/cam_window_capture_if.sv
// Camera pin bundle plus the per-window RAM write ports.
interface cam_window_capture_if
  import cam_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_WIN = NUM_WIN_DEF
);

  logic                      vsync;
  logic                      href;
  logic [DATA_W-1:0]         d;
  logic [NUM_WIN-1:0]        wr_en;
  logic [NUM_WIN*ADDR_W-1:0] wr_addr;
  logic [NUM_WIN*DATA_W-1:0] wr_data;

  modport master (
    output vsync, href, d,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  vsync, href, d,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/cam_win_writer.sv
// One capture window: shadow config, hit/decimation test,
// address counter, overflow flag and registered RAM write.
module cam_win_writer
  import cam_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int X_W    = X_W_DEF,
  parameter int Y_W    = Y_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEC_W  = DEC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              stb,
  input  logic [X_W-1:0]    hcnt,
  input  logic [Y_W-1:0]    vcnt,
  input  logic [DATA_W-1:0] d,
  input  logic [X_W-1:0]    x0,
  input  logic [X_W-1:0]    x1,
  input  logic [Y_W-1:0]    y0,
  input  logic [Y_W-1:0]    y1,
  input  logic [DEC_W-1:0]  dec,
  input  logic [ADDR_W-1:0] limit,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              ovf
);

  logic [X_W-1:0]    sx0, sx1;
  logic [Y_W-1:0]    sy0, sy1;
  logic [DEC_W-1:0]  sdec;
  logic [ADDR_W-1:0] slim;

  // Extra top bit keeps a full-range limit from wrapping back to 0.
  logic [ADDR_W:0]   addr;

  logic [X_W-1:0] dx, xmask;
  logic [Y_W-1:0] dy, ymask;
  logic           in_x, in_y, hit, room;

  always_comb begin
    dx    = hcnt - sx0;
    dy    = vcnt - sy0;
    xmask = ~({X_W{1'b1}} << sdec);
    ymask = ~({Y_W{1'b1}} << sdec);
    in_x  = (hcnt >= sx0) && (hcnt <= sx1);
    in_y  = (vcnt >= sy0) && (vcnt <= sy1);
    hit   = stb && in_x && in_y &&
            ((dx & xmask) == '0) &&
            ((dy & ymask) == '0);
    room  = addr <= {1'b0, slim};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx0     <= '0;
      sx1     <= '0;
      sy0     <= '0;
      sy1     <= '0;
      sdec    <= '0;
      slim    <= '0;
      addr    <= '0;
      ovf     <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (vsync) begin
      sx0   <= x0;
      sx1   <= x1;
      sy0   <= y0;
      sy1   <= y1;
      sdec  <= dec;
      slim  <= limit;
      addr  <= '0;
      ovf   <= 1'b0;
      wr_en <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (hit && room) begin
        wr_en   <= 1'b1;
        wr_addr <= addr[ADDR_W-1:0];
        wr_data <= d;
        addr    <= addr + (ADDR_W+1)'(1);
      end else if (hit) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_window_capture.sv
// Camera timing decoder feeding NUM_WIN independent window writers.
module cam_window_capture
  import cam_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int X_W        = X_W_DEF,
  parameter int Y_W        = Y_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int NUM_WIN    = NUM_WIN_DEF,
  parameter int PIX_PHASES = PIX_PHASES_DEF,
  parameter int DEC_W      = DEC_W_DEF
) (
  input  logic                      pclk,
  input  logic                      reset,
  cam_window_capture_if.slave       bus,
  input  logic [NUM_WIN*X_W-1:0]    cfg_x0,
  input  logic [NUM_WIN*X_W-1:0]    cfg_x1,
  input  logic [NUM_WIN*Y_W-1:0]    cfg_y0,
  input  logic [NUM_WIN*Y_W-1:0]    cfg_y1,
  input  logic [NUM_WIN*DEC_W-1:0]  cfg_dec,
  input  logic [NUM_WIN*ADDR_W-1:0] cfg_limit,
  output logic [NUM_WIN-1:0]        win_ovf,
  output logic                      frame_done,
  output logic [7:0]                frame_cnt
);

  localparam int PH_W = (PIX_PHASES > 1) ? $clog2(PIX_PHASES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PIX_PHASES - 1);
  localparam logic [X_W-1:0]  X_MAX   = '1;
  localparam logic [Y_W-1:0]  Y_MAX   = '1;

  logic [PH_W-1:0] phase;
  logic [X_W-1:0]  hcnt;
  logic [Y_W-1:0]  vcnt;
  logic            href_d, vsync_d, seen;
  logic            pix_stb, stb, line_end;

  assign pix_stb  = bus.href && (phase == PH_LAST);
  assign stb      = pix_stb && !bus.vsync;
  assign line_end = !bus.href && href_d && (hcnt != '0);

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      phase  <= '0;
      hcnt   <= '0;
      href_d <= 1'b0;
    end else begin
      href_d <= bus.href;
      if (!bus.href || phase == PH_LAST)
        phase <= '0;
      else
        phase <= phase + PH_W'(1);
      if (!bus.href)
        hcnt <= '0;
      else if (pix_stb && hcnt != X_MAX)
        hcnt <= hcnt + X_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset)
      vcnt <= '0;
    else if (bus.vsync)
      vcnt <= '0;
    else if (line_end && vcnt != Y_MAX)
      vcnt <= vcnt + Y_W'(1);
  end

  // A frame only counts if a line completed since the last vsync.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vsync_d    <= 1'b0;
      seen       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vsync_d    <= bus.vsync;
      frame_done <= 1'b0;
      if (bus.vsync) begin
        seen <= 1'b0;
        if (!vsync_d && seen) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
        end
      end else if (line_end) begin
        seen <= 1'b1;
      end
    end
  end

  logic [NUM_WIN-1:0]        wen;
  logic [NUM_WIN*ADDR_W-1:0] wadr;
  logic [NUM_WIN*DATA_W-1:0] wdat;

  for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
    cam_win_writer #(
      .DATA_W (DATA_W),
      .X_W    (X_W),
      .Y_W    (Y_W),
      .ADDR_W (ADDR_W),
      .DEC_W  (DEC_W)
    ) u_win (
      .clk     (pclk),
      .rst     (reset),
      .vsync   (bus.vsync),
      .stb     (stb),
      .hcnt    (hcnt),
      .vcnt    (vcnt),
      .d       (bus.d),
      .x0      (X_W'(slice(bus_t'(cfg_x0), k, X_W))),
      .x1      (X_W'(slice(bus_t'(cfg_x1), k, X_W))),
      .y0      (Y_W'(slice(bus_t'(cfg_y0), k, Y_W))),
      .y1      (Y_W'(slice(bus_t'(cfg_y1), k, Y_W))),
      .dec     (DEC_W'(slice(bus_t'(cfg_dec), k, DEC_W))),
      .limit   (ADDR_W'(slice(bus_t'(cfg_limit), k, ADDR_W))),
      .wr_en   (wen[k]),
      .wr_addr (wadr[k*ADDR_W +: ADDR_W]),
      .wr_data (wdat[k*DATA_W +: DATA_W]),
      .ovf     (win_ovf[k])
    );
  end

  assign bus.wr_en   = wen;
  assign bus.wr_addr = wadr;
  assign bus.wr_data = wdat;

endmodule

// File: tb/tb_cam_window_capture.sv
// Directed bench for cam_window_capture with a per-window write scoreboard.
module tb_cam_window_capture;
  import cam_pkg::*;

  localparam int DW = 3, XW = 10, YW = 9, AW = 16;
  localparam int NW = 2, PP = 2, SW = 2;
  localparam int W = 40, H = 24;

  logic pclk = 1'b0;
  logic reset;
  logic [NW*XW-1:0] cfg_x0, cfg_x1;
  logic [NW*YW-1:0] cfg_y0, cfg_y1;
  logic [NW*SW-1:0] cfg_dec;
  logic [NW*AW-1:0] cfg_limit;
  logic [NW-1:0]    win_ovf;
  logic             frame_done;
  logic [7:0]       frame_cnt;

  cam_window_capture_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_WIN(NW)) bus ();

  cam_window_capture #(
    .DATA_W(DW), .X_W(XW), .Y_W(YW), .ADDR_W(AW),
    .NUM_WIN(NW), .PIX_PHASES(PP), .DEC_W(SW)
  ) dut (
    .pclk(pclk), .reset(reset), .bus(bus.slave),
    .cfg_x0(cfg_x0), .cfg_x1(cfg_x1),
    .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
    .cfg_dec(cfg_dec), .cfg_limit(cfg_limit),
    .win_ovf(win_ovf), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t q0[$], q1[$];
  int n_chk = 0, n_fail = 0, cyc_n = 0, n_done = 0;
  int wcnt[NW], wbase[NW];
  int sx0[NW], sx1[NW], sy0[NW], sy1[NW], sdec[NW], slim[NW];
  int m_addr[NW];
  bit lines_seen;
  int exp_done, done_base;

  task automatic check(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge pclk) cyc_n <= cyc_n + 1;

  always @(negedge pclk) begin : mon
    exp_t g, e;
    int qs;
    if (frame_done) n_done++;
    for (int k = 0; k < NW; k++) begin
      if (bus.wr_en[k]) begin
        wcnt[k]++;
        qs = (k == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
          check($sformatf("wr%0d_spurious", k), 96'(bus.wr_en[k]), 96'(0));
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          g.addr = 32'(bus.wr_addr[k*AW +: AW]);
          g.data = 32'(bus.wr_data[k*DW +: DW]);
          g.cyc  = cyc_n;
          check($sformatf("wr%0d_addr_data_cyc", k), g, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_win(input int k, input int x0, input int x1,
                         input int y0, input int y1, input int s,
                         input int lim);
    cfg_x0[k*XW +: XW]    = XW'(x0);
    cfg_x1[k*XW +: XW]    = XW'(x1);
    cfg_y0[k*YW +: YW]    = YW'(y0);
    cfg_y1[k*YW +: YW]    = YW'(y1);
    cfg_dec[k*SW +: SW]   = SW'(s);
    cfg_limit[k*AW +: AW] = AW'(lim);
  endtask

  task automatic model(input int x, input int y, input logic [DW-1:0] v);
    exp_t e;
    int step;
    for (int k = 0; k < NW; k++) begin
      step = 1 << sdec[k];
      if (x >= sx0[k] && x <= sx1[k] && y >= sy0[k] && y <= sy1[k] &&
          (x - sx0[k]) % step == 0 && (y - sy0[k]) % step == 0) begin
        if (m_addr[k] <= slim[k]) begin
          e.addr = m_addr[k];
          e.data = 32'(v);
          e.cyc  = cyc_n + 1;
          if (k == 0) q0.push_back(e);
          else        q1.push_back(e);
          m_addr[k]++;
        end
      end
    end
  endtask

  task automatic pixel(input int x, input int y);
    logic [DW-1:0] v;
    v = DW'($urandom_range(0, 7));
    for (int p = 0; p < PP; p++) begin
      bus.href = 1'b1;
      bus.d    = (p == PP-1) ? v : ~v;
      if (p == PP-1) model(x, y, v);
      tick();
    end
  endtask

  task automatic line(input int y);
    for (int x = 0; x < W; x++) pixel(x, y);
    bus.href = 1'b0;
    bus.d    = '0;
    repeat (4) tick();
    lines_seen = 1'b1;
  endtask

  task automatic vsync_pulse(input string tag);
    bus.vsync = 1'b1;
    if (lines_seen) exp_done++;
    lines_seen = 1'b0;
    for (int k = 0; k < NW; k++) begin
      sx0[k]    = int'(cfg_x0[k*XW +: XW]);
      sx1[k]    = int'(cfg_x1[k*XW +: XW]);
      sy0[k]    = int'(cfg_y0[k*YW +: YW]);
      sy1[k]    = int'(cfg_y1[k*YW +: YW]);
      sdec[k]   = int'(cfg_dec[k*SW +: SW]);
      slim[k]   = int'(cfg_limit[k*AW +: AW]);
      m_addr[k] = 0;
    end
    repeat (3) tick();
    bus.vsync = 1'b0;
    repeat (2) tick();
    check({tag, "_done_pulses"}, 96'(n_done - done_base), 96'(exp_done));
    check({tag, "_frame_cnt"}, 96'(frame_cnt), 96'(exp_done % 256));
    check({tag, "_ovf_clear"}, 96'(win_ovf), 96'(0));
    for (int k = 0; k < NW; k++) wbase[k] = wcnt[k];
  endtask

  task automatic frame_checks(input string tag, input int e0, input int e1,
                              input logic [NW-1:0] ovf);
    check({tag, "_wr0_count"}, 96'(wcnt[0] - wbase[0]), 96'(e0));
    check({tag, "_wr1_count"}, 96'(wcnt[1] - wbase[1]), 96'(e1));
    check({tag, "_sb_empty"}, 96'(q0.size() + q1.size()), 96'(0));
    check({tag, "_ovf"}, 96'(win_ovf), 96'(ovf));
  endtask

  initial begin
    reset     = 1'b1;
    bus.vsync = 1'b0;
    bus.href  = 1'b0;
    bus.d     = '0;
    cfg_x0 = '0; cfg_x1 = '0; cfg_y0 = '0; cfg_y1 = '0;
    cfg_dec = '0; cfg_limit = '0;
    repeat (3) tick();
    check("rst_wr_en", 96'(bus.wr_en), 96'(0));
    check("rst_wr_addr", 96'(bus.wr_addr), 96'(0));
    check("rst_wr_data", 96'(bus.wr_data), 96'(0));
    check("rst_ovf", 96'(win_ovf), 96'(0));
    check("rst_frame_done", 96'(frame_done), 96'(0));
    check("rst_frame_cnt", 96'(frame_cnt), 96'(0));
    reset = 1'b0;
    tick();

    // Frame A config, interrupted by a reset partway through a line
    set_win(0, 10, 19, 4, 13, 0, 9999);
    set_win(1, 8, 23, 6, 13, 1, 2047);
    vsync_pulse("pre");
    for (int y = 0; y < 6; y++) line(y);
    for (int x = 0; x < 16; x++) pixel(x, 6);
    check("pre_reset_addr_live", 96'(bus.wr_addr[AW-1:0]), 96'(25));
    bus.href = 1'b1;
    reset = 1'b1;
    #1;
    check("midline_rst_wr_en", 96'(bus.wr_en), 96'(0));
    check("midline_rst_wr_addr", 96'(bus.wr_addr), 96'(0));
    check("midline_rst_wr_data", 96'(bus.wr_data), 96'(0));
    check("midline_rst_frame_cnt", 96'(frame_cnt), 96'(0));
    q0.delete();
    q1.delete();
    lines_seen = 1'b0;
    exp_done   = 0;
    done_base  = n_done;
    tick();
    bus.href = 1'b0;
    reset = 1'b0;
    repeat (2) tick();

    vsync_pulse("a_start");
    for (int y = 0; y < H; y++) line(y);
    frame_checks("a", 100, 32, 2'b00);

    // Overflow: 10x20 window with room for 100; window 1 disabled
    set_win(0, 5, 14, 2, 21, 0, 99);
    set_win(1, 50, 40, 0, 23, 0, 2047);
    vsync_pulse("b_start");
    for (int y = 0; y < H; y++) line(y);
    frame_checks("b", 100, 0, 2'b01);

    // Mid-frame x0 change must wait for the next vsync
    set_win(0, 10, 25, 2, 3, 0, 9999);
    vsync_pulse("c_start");
    for (int y = 0; y < 2; y++) line(y);
    cfg_x0[XW-1:0] = XW'(20);
    for (int y = 2; y < H; y++) line(y);
    frame_checks("c", 32, 0, 2'b00);

    vsync_pulse("d_start");
    for (int y = 0; y < H; y++) line(y);
    frame_checks("d", 12, 0, 2'b00);

    vsync_pulse("e_end");
    vsync_pulse("e_empty");
    check("final_frame_cnt", 96'(frame_cnt), 96'(4));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
